memory_stage: RTL and testbench

//  Consumer end of the EX/MEM pipeline interface: takes the EX/MEM register outputs
//  (address/ALU result, store data, control) and drives a variable-latency data-memory
//  req/ack port. Stalls upstream stages while an access is outstanding, then loads the
//  MEM/WB registers. Also provides a forwarding value, sticky halt, and a timeout/alignment error.

---
 rtl/memory_stage_pkg.sv | 20 ++
 rtl/mem_timeout_ctr.sv | 36 +++
 rtl/memory_stage.sv | 196 +++++++++++++++++++
 tb/tb_memory_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM stage: controller state encoding and
// the width rule for the BUSY-cycle timeout counter.
package memory_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } mem_state_e;

  // Counter width able to hold TIMEOUT-1; never narrower than one bit.
  function automatic int ctr_width(input int timeout);
    if (timeout < 2) begin
      return 1;
    end else begin
      return $clog2(timeout);
    end
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// BUSY-cycle counter for the MEM stage. Counts enabled cycles from zero
// after a clear; tc is high on the TIMEOUT-th enabled cycle.
module mem_timeout_ctr
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = ctr_width(TIMEOUT);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [CW-1:0] count_r;

  // Count cycles spent waiting; restart from zero whenever cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (enable) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = enable & (count_r == TC_VAL);

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: turns EX/MEM loads/stores into a req/ack memory
// access, stalls the front of the pipe while it waits, and loads MEM/WB.
// A timeout, memory fault, misaligned or read+write access parks the
// stage in a sticky error state until reset.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT     = 64,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ALUO_EXMEM,
  input  logic [15:0] Rd2_EXMEM,
  input  logic [2:0]  WrR_EXMEM,
  input  logic        RegWrite_EXMEM,
  input  logic        MemtoReg_EXMEM,
  input  logic        MemWrite_EXMEM,
  input  logic        MemRead_EXMEM,
  input  logic        halt_EXMEM,
  input  logic        jumpAndLink_EXMEM,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        mem_err,
  output logic        stall_MEM,
  output logic [15:0] ALUO_MEMWB,
  output logic [15:0] MemData_MEMWB,
  output logic [2:0]  WrR_MEMWB,
  output logic        RegWrite_MEMWB,
  output logic        MemtoReg_MEMWB,
  output logic        halt_MEMWB,
  output logic        jumpAndLink_MEMWB,
  output logic [15:0] fwd_MEM,
  output logic        err
);

  mem_state_e state_r;
  mem_state_e next_state_s;
  logic       halted_r;
  logic       err_r;
  logic       access_s;
  logic       bad_access_s;
  logic       req_s;
  logic       stall_s;
  logic       tc_s;
  logic       done_s;
  logic       rd_done_s;

  // An access is only live while not halted and not already in error.
  assign access_s     = (MemRead_EXMEM | MemWrite_EXMEM) & ~halted_r & ~err_r;
  assign bad_access_s = (MemRead_EXMEM & MemWrite_EXMEM) | (ALIGN_CHECK & ALUO_EXMEM[0]);

  // Next-state, request and stall decode.
  always_comb begin
    next_state_s = state_r;
    req_s        = 1'b0;
    stall_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (access_s) begin
          if (bad_access_s) begin
            // Malformed access never reaches the memory.
            next_state_s = ST_ERR;
            stall_s      = 1'b1;
          end else begin
            req_s = 1'b1;
            if (mem_err) begin
              next_state_s = ST_ERR;
              stall_s      = 1'b1;
            end else if (mem_ack) begin
              // Zero-wait completion: no stall, stay idle.
              next_state_s = ST_IDLE;
              stall_s      = 1'b0;
            end else begin
              next_state_s = ST_BUSY;
              stall_s      = 1'b1;
            end
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        req_s = 1'b1;
        if (mem_err) begin
          next_state_s = ST_ERR;
          stall_s      = 1'b1;
        end else if (mem_ack) begin
          // Ack beats a coincident timeout.
          next_state_s = ST_IDLE;
          stall_s      = 1'b0;
        end else if (tc_s) begin
          next_state_s = ST_ERR;
          stall_s      = 1'b1;
        end else begin
          next_state_s = ST_BUSY;
          stall_s      = 1'b1;
        end
      end
      ST_ERR: begin
        next_state_s = ST_ERR;
        stall_s      = 1'b1;
      end
      default: begin
        next_state_s = ST_IDLE;
        stall_s      = 1'b0;
      end
    endcase
  end

  assign done_s    = req_s & mem_ack & ~mem_err;
  assign rd_done_s = done_s & ~MemWrite_EXMEM;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_r != ST_BUSY),
    .enable (state_r == ST_BUSY),
    .tc     (tc_s)
  );

  // Controller state and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      err_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      err_r   <= (next_state_s == ST_ERR);
    end
  end

  // Sticky halt, taken only when the halt instruction actually advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_r <= 1'b0;
    end else if (!stall_s && halt_EXMEM) begin
      halted_r <= 1'b1;
    end else begin
      halted_r <= halted_r;
    end
  end

  // MEM/WB pipeline register; stalled cycles insert a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUO_MEMWB        <= 16'h0000;
      WrR_MEMWB         <= 3'd0;
      RegWrite_MEMWB    <= 1'b0;
      MemtoReg_MEMWB    <= 1'b0;
      halt_MEMWB        <= 1'b0;
      jumpAndLink_MEMWB <= 1'b0;
    end else begin
      ALUO_MEMWB <= ALUO_EXMEM;
      WrR_MEMWB  <= WrR_EXMEM;
      if (stall_s) begin
        RegWrite_MEMWB    <= 1'b0;
        MemtoReg_MEMWB    <= 1'b0;
        halt_MEMWB        <= 1'b0;
        jumpAndLink_MEMWB <= 1'b0;
      end else begin
        RegWrite_MEMWB    <= RegWrite_EXMEM;
        MemtoReg_MEMWB    <= MemtoReg_EXMEM;
        halt_MEMWB        <= halt_EXMEM;
        jumpAndLink_MEMWB <= jumpAndLink_EXMEM;
      end
    end
  end

  // Load data is captured only on a completed read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MemData_MEMWB <= 16'h0000;
    end else if (rd_done_s) begin
      MemData_MEMWB <= mem_rdata;
    end else begin
      MemData_MEMWB <= MemData_MEMWB;
    end
  end

  // Reset gates the request immediately so an in-flight access is dropped.
  assign mem_req   = req_s & ~rst;
  assign stall_MEM = stall_s & ~rst;
  assign mem_wr    = mem_req & MemWrite_EXMEM;
  assign mem_addr  = mem_req ? ALUO_EXMEM : 16'h0000;
  assign mem_wdata = mem_req ? Rd2_EXMEM : 16'h0000;
  assign fwd_MEM   = MemtoReg_EXMEM ? mem_rdata : ALUO_EXMEM;
  assign err       = err_r;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a driver issues EX/MEM instructions
// and pushes expected MEM/WB results, a memory responder with its own
// storage answers requests after a chosen number of wait cycles, and a
// monitor compares MEM/WB every time the stage advances.
module tb_memory_stage;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic [15:0] ALUO_EXMEM, Rd2_EXMEM;
  logic [2:0]  WrR_EXMEM;
  logic        RegWrite_EXMEM, MemtoReg_EXMEM, MemWrite_EXMEM, MemRead_EXMEM;
  logic        halt_EXMEM, jumpAndLink_EXMEM;
  logic        mem_req, mem_wr, mem_ack, mem_err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_MEM;
  logic [15:0] ALUO_MEMWB, MemData_MEMWB, fwd_MEM;
  logic [2:0]  WrR_MEMWB;
  logic        RegWrite_MEMWB, MemtoReg_MEMWB, halt_MEMWB, jumpAndLink_MEMWB;
  logic        err;

  memory_stage #(.TIMEOUT(TO), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ALUO_EXMEM(ALUO_EXMEM), .Rd2_EXMEM(Rd2_EXMEM), .WrR_EXMEM(WrR_EXMEM),
    .RegWrite_EXMEM(RegWrite_EXMEM), .MemtoReg_EXMEM(MemtoReg_EXMEM),
    .MemWrite_EXMEM(MemWrite_EXMEM), .MemRead_EXMEM(MemRead_EXMEM),
    .halt_EXMEM(halt_EXMEM), .jumpAndLink_EXMEM(jumpAndLink_EXMEM),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .stall_MEM(stall_MEM),
    .ALUO_MEMWB(ALUO_MEMWB), .MemData_MEMWB(MemData_MEMWB), .WrR_MEMWB(WrR_MEMWB),
    .RegWrite_MEMWB(RegWrite_MEMWB), .MemtoReg_MEMWB(MemtoReg_MEMWB),
    .halt_MEMWB(halt_MEMWB), .jumpAndLink_MEMWB(jumpAndLink_MEMWB),
    .fwd_MEM(fwd_MEM), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] aluo;
    logic [2:0]  wrr;
    logic        rw;
    logic        m2r;
    logic        hlt;
    logic        jal;
    logic [15:0] mdata;
    int          stalls;
  } exp_t;

  typedef struct {
    int          wait_n;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  exp_t        sb[$];
  req_t        rq[$];
  logic [15:0] dev [logic [15:0]];
  logic [15:0] model_mem [logic [15:0]];
  logic [15:0] exp_md = 16'h0000;
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Initial memory image for locations never written.
  function automatic logic [15:0] image(input logic [15:0] a);
    return a ^ 16'h3C3C;
  endfunction

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    else return image(a);
  endfunction

  function automatic logic [15:0] dev_rd(input logic [15:0] a);
    if (dev.exists(a)) return dev[a];
    else return image(a);
  endfunction

  task automatic nop();
    ALUO_EXMEM = 16'h0000; Rd2_EXMEM = 16'h0000; WrR_EXMEM = 3'd0;
    RegWrite_EXMEM = 1'b0; MemtoReg_EXMEM = 1'b0; MemWrite_EXMEM = 1'b0;
    MemRead_EXMEM = 1'b0; halt_EXMEM = 1'b0; jumpAndLink_EXMEM = 1'b0;
  endtask

  task automatic push_req(input int wait_n, input logic wr, input logic [15:0] a, input logic [15:0] d);
    req_t r;
    r.wait_n = wait_n; r.wr = wr; r.addr = a; r.wdata = d;
    rq.push_back(r);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the instruction advanced.
  task automatic issue(input logic [15:0] aluo, input logic [15:0] rd2, input logic [2:0] wrr,
                       input logic rw, input logic m2r, input logic mw, input logic mr,
                       input logic hlt, input logic jal, input int wait_n, input bit acc);
    exp_t e;
    bit   consumed;
    ALUO_EXMEM = aluo; Rd2_EXMEM = rd2; WrR_EXMEM = wrr;
    RegWrite_EXMEM = rw; MemtoReg_EXMEM = m2r; MemWrite_EXMEM = mw;
    MemRead_EXMEM = mr; halt_EXMEM = hlt; jumpAndLink_EXMEM = jal;
    e.stalls = 0;
    if (acc) begin
      push_req(wait_n, mw, aluo, rd2);
      if (mr) exp_md = model_rd(aluo);
      if (mw) model_mem[aluo] = rd2;
      e.stalls = wait_n;
    end
    e.aluo = aluo; e.wrr = wrr; e.rw = rw; e.m2r = m2r; e.hlt = hlt; e.jal = jal;
    e.mdata = exp_md;
    sb.push_back(e);
    consumed = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 0 && !mr && !mw && !m2r) chk("fwd_MEM", 32'(fwd_MEM), 32'(aluo));
      if (!stall_MEM) begin
        consumed = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    chk("instr_advanced", 32'(consumed), 32'd1);
  endtask

  task automatic start_phase();
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  task automatic end_phase();
    nop();
    @(negedge clk); #1;
    mon_en = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic do_reset();
    nop();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    rq.delete();
    exp_md = 16'h0000;
  endtask

  // Memory responder: acks each request after its scheduled wait cycles.
  req_t cur;
  int   left;
  bit   in_req = 1'b0;
  initial begin
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 16'h0000; left = 0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        mem_ack = 1'b0; in_req = 1'b0;
      end else if (mem_req) begin
        if (!in_req) begin
          in_req = 1'b1;
          chk("req_expected", 32'(rq.size() != 0), 32'd1);
          if (rq.size() != 0) begin
            cur = rq.pop_front();
            chk("req_addr", 32'(mem_addr), 32'(cur.addr));
            chk("req_wr", 32'(mem_wr), 32'(cur.wr));
            if (cur.wr) chk("req_wdata", 32'(mem_wdata), 32'(cur.wdata));
          end else begin
            cur.wait_n = 1000; cur.addr = mem_addr; cur.wr = mem_wr; cur.wdata = mem_wdata;
          end
          left = cur.wait_n;
        end else begin
          chk("addr_stable", 32'(mem_addr), 32'(cur.addr));
        end
        if (left == 0) begin
          mem_ack = 1'b1;
          if (mem_wr) dev[mem_addr] = mem_wdata;
          else mem_rdata = dev_rd(mem_addr);
          in_req = 1'b0;
        end else begin
          mem_ack = 1'b0; mem_rdata = 16'($urandom); left--;
        end
      end else begin
        mem_ack = 1'b0; mem_rdata = 16'($urandom); in_req = 1'b0;
      end
    end
  end

  // Monitor: after each edge, check a bubble or pop and compare one result.
  exp_t e_mon;
  bit   prev_valid = 1'b0;
  bit   prev_stall = 1'b0;
  int   stall_run = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        prev_valid = 1'b0; stall_run = 0;
      end else begin
        if (prev_valid) begin
          if (prev_stall) begin
            chk("bubble_RegWrite", 32'(RegWrite_MEMWB), 32'd0);
            chk("bubble_MemtoReg", 32'(MemtoReg_MEMWB), 32'd0);
            chk("bubble_halt", 32'(halt_MEMWB), 32'd0);
            chk("bubble_jal", 32'(jumpAndLink_MEMWB), 32'd0);
          end else begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
              e_mon = sb.pop_front();
              chk("ALUO_MEMWB", 32'(ALUO_MEMWB), 32'(e_mon.aluo));
              chk("WrR_MEMWB", 32'(WrR_MEMWB), 32'(e_mon.wrr));
              chk("RegWrite_MEMWB", 32'(RegWrite_MEMWB), 32'(e_mon.rw));
              chk("MemtoReg_MEMWB", 32'(MemtoReg_MEMWB), 32'(e_mon.m2r));
              chk("halt_MEMWB", 32'(halt_MEMWB), 32'(e_mon.hlt));
              chk("jal_MEMWB", 32'(jumpAndLink_MEMWB), 32'(e_mon.jal));
              chk("MemData_MEMWB", 32'(MemData_MEMWB), 32'(e_mon.mdata));
              chk("stall_cycles", 32'(stall_run), 32'(e_mon.stalls));
            end
            stall_run = 0;
          end
        end
        prev_valid = 1'b1;
        prev_stall = stall_MEM;
        if (stall_MEM) stall_run++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind, w, nreq;
    bit          got;
    logic [15:0] a, d;
    logic [2:0]  r;

    dev[16'h0040] = 16'hBEEF;
    model_mem[16'h0040] = 16'hBEEF;

    // Reset with a load sitting on the inputs: nothing may leak out.
    rst = 1'b1;
    nop();
    ALUO_EXMEM = 16'h0040; MemRead_EXMEM = 1'b1; MemtoReg_EXMEM = 1'b1; RegWrite_EXMEM = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall_MEM), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ALUO_MEMWB", 32'(ALUO_MEMWB), 32'd0);
    chk("rst_RegWrite_MEMWB", 32'(RegWrite_MEMWB), 32'd0);
    chk("rst_MemData_MEMWB", 32'(MemData_MEMWB), 32'd0);
    nop();
    rst = 1'b0;
    exp_md = 16'h0000;

    // Directed: ALU op, 3-wait load, zero-wait store, ack coincident with timeout.
    start_phase();
    issue(16'h1234, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    issue(16'h0040, 16'h0000, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1);
    issue(16'h0010, 16'h00FF, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    issue(16'h0010, 16'h0000, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, TO, 1'b1);

    // Random mix of ALU ops, loads and stores over a small address window.
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 2);
      w    = $urandom_range(0, 4);
      a    = 16'($urandom);
      d    = 16'($urandom);
      r    = 3'($urandom);
      if (kind == 0) begin
        issue(a, d, r, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom), 0, 1'b0);
      end else begin
        a = {11'h000, a[4:1], 1'b0};
        if (kind == 1) issue(a, d, r, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, w, 1'b1);
        else           issue(a, d, r, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, w, 1'b1);
      end
    end

    // Halt: afterwards loads and stores pass through without touching memory.
    issue(16'h0AAA, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    issue(16'h0004, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    issue(16'h0006, 16'h5555, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    end_phase();

    // Timeout: no ack ever, error after TO BUSY cycles.
    do_reset();
    ALUO_EXMEM = 16'h0020; MemRead_EXMEM = 1'b1; MemtoReg_EXMEM = 1'b1; RegWrite_EXMEM = 1'b1;
    push_req(1000, 1'b0, 16'h0020, 16'h0000);
    nreq = 0;
    got  = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (err) got = 1'b1;
      else if (mem_req) nreq++;
    end
    chk("timeout_err", 32'(got), 32'd1);
    chk("timeout_req_cycles", 32'(nreq), 32'(TO + 1));
    chk("timeout_req_low", 32'(mem_req), 32'd0);
    chk("timeout_stall", 32'(stall_MEM), 32'd1);
    nop();
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    chk("err_stall_sticky", 32'(stall_MEM), 32'd1);

    // Misaligned load: error, never a request.
    do_reset();
    ALUO_EXMEM = 16'h0041; MemRead_EXMEM = 1'b1; MemtoReg_EXMEM = 1'b1; RegWrite_EXMEM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("unaligned_no_req", 32'(mem_req), 32'd0);
    end
    chk("unaligned_err", 32'(err), 32'd1);

    // Reset in the middle of a wait drops req/stall at once; then a clean load.
    do_reset();
    ALUO_EXMEM = 16'h0080; MemRead_EXMEM = 1'b1; MemtoReg_EXMEM = 1'b1; RegWrite_EXMEM = 1'b1;
    push_req(1000, 1'b0, 16'h0080, 16'h0000);
    repeat (3) @(negedge clk);
    chk("busy_req", 32'(mem_req), 32'd1);
    chk("busy_stall", 32'(stall_MEM), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(mem_req), 32'd0);
    chk("async_rst_stall", 32'(stall_MEM), 32'd0);
    nop();
    rq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_md = 16'h0000;
    start_phase();
    issue(16'h0080, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1);
    end_phase();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
